operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: decode-to-operand handshake.
REQ-006 SHALL have ports rs1, rs2, rd input ADDR_W, rd_we input 1, is_load input 1, pc input DATA_W, imm input DATA_W: decoded instruction fields.
REQ-007 SHALL have ports rf_data1, rf_data2 input DATA_W: combinational register-file read data for rs1/rs2.
REQ-008 SHALL have port ex_result input DATA_W: combinational EX result of the instruction held in this block's output register.
REQ-009 SHALL have ports mem_valid input 1, mem_we input 1, mem_rd input ADDR_W, mem_result input DATA_W: MEM-stage writer.
REQ-010 SHALL have port flush input 1: squash held and incoming instruction.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1: operand-to-EX handshake.
REQ-012 SHALL have registered outputs out_op1, out_op2, out_pc, out_imm (DATA_W), out_rd (ADDR_W), out_rd_we, out_is_load (1).
REQ-013 SHALL have output hazard_stall 1 (combinational) and stall_cycles 32 (registered).

Function
REQ-014 Operand select per source, priority: EX match, then MEM match, then rf data.
REQ-015 EX match: out_valid && out_rd_we && out_rd==rsN && rsN!=0.
REQ-016 MEM match: mem_valid && mem_we && mem_rd==rsN && rsN!=0.
REQ-017 rsN==0 SHALL select rf data (never forwarded); WB-stage writes need no bypass since the register file writes on the falling edge.
REQ-018 Load-use hazard: in_valid && EX match on rs1 or rs2 && out_is_load; hazard_stall=1.
REQ-019 in_ready = !hazard_stall && (out_ready || !out_valid).
REQ-020 Capture: in_valid && in_ready -> output register loads selected operands and fields next edge; latency 1 cycle.
REQ-021 Hazard with out_ready=1: output register loads a bubble (out_valid=0); instruction stays at input; next cycle hazard clears (load now in MEM) and MEM forwarding applies.
REQ-022 out_ready=0 && out_valid=1: output register holds all values unchanged.
REQ-023 Neither capture nor hazard and out_ready=1: out_valid clears next edge.
REQ-024 flush=1: out_valid=0 next edge; overrides capture and hold; in_ready forced 0 that cycle.
REQ-025 stall_cycles increments by 1 on each edge with hazard_stall=1 && !flush, saturating at 0xFFFFFFFF.
REQ-026 Output fields of a bubble SHALL be 0 (out_rd_we=0, out_is_load=0).

Reset
REQ-027 reset=1 at an edge: out_valid, all out_* data/fields, stall_cycles SHALL be 0; reset overrides flush and capture.
REQ-028 Reset mid-stall: instruction at input is not captured; after reset release normal capture resumes the next cycle.

Configuration
REQ-029 Macro OPERAND_FORWARDING_EN defined: forwarding per REQ-014..REQ-021.
REQ-030 Macro undefined: operands always from rf data; hazard_stall=1 for any EX or MEM match (load or not); stall_cycles counts those cycles; all other behaviour unchanged.

Verification
REQ-031 add x5 captured, ex_result=0x2A, next in rs1=5 -> out_op1=0x2A one cycle later, hazard_stall=0 (EN defined).
REQ-032 load x7 in EX, in rs2=7 -> hazard_stall=1 one cycle, bubble out, then out_op2=mem_result=0x1234, stall_cycles=1.
REQ-033 rs1=0, EX rd=0 writing 0xFF, rf_data1=0 -> out_op1=0, no stall.
REQ-034 EX rd=3 result 0x11 and MEM rd=3 result 0x22, rs1=3 -> out_op1=0x11.
REQ-035 out_ready=0 three cycles with valid out -> outputs stable, in_ready=0; flush -> out_valid=0 next edge.
REQ-036 EN undefined, MEM rd=4 pending, rs1=4 -> hazard_stall=1 until mem_valid=0, then out_op1=rf_data1.

Source files
------------

// File: rtl/operand_stage.sv
// Operand stage: sits between decode and EX. Selects source operands,
// detects hazards against the instruction held in the output register and
// the MEM-stage writer, and presents a registered instruction to EX through
// a valid/ready handshake.
//
// Configuration macro: OPERAND_FORWARDING_EN
//   defined   - EX/MEM results are bypassed into the operands; only a
//               load-use dependency on the instruction in EX stalls.
//   undefined - operands always come from the register file; any dependency
//               on a pending EX or MEM write stalls until it has retired.
module operand_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  // decode-to-operand handshake and decoded fields
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_we,
  input  logic              is_load,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  // register-file read data for rs1/rs2
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  // EX result of the instruction held in the output register
  input  logic [DATA_W-1:0] ex_result,
  // MEM-stage writer
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  // squash
  input  logic              flush,
  // operand-to-EX handshake and registered instruction
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  // hazard status
  output logic              hazard_stall,
  output logic [31:0]       stall_cycles
);

  // x0 is hard-wired to zero, so a write to it is never a real dependency.
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic [DATA_W-1:0] op1_sel, op2_sel;
  logic capture;

  assign ex_hit1  = out_valid && out_rd_we && (out_rd == rs1) && (rs1 != '0);
  assign ex_hit2  = out_valid && out_rd_we && (out_rd == rs2) && (rs2 != '0);
  assign mem_hit1 = mem_valid && mem_we && (mem_rd == rs1) && (rs1 != '0);
  assign mem_hit2 = mem_valid && mem_we && (mem_rd == rs2) && (rs2 != '0);

  // Operand selection and hazard detection.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    op1_sel      = rf_data1;
    op2_sel      = rf_data2;
    hazard_stall = 1'b0;
`ifdef OPERAND_FORWARDING_EN
    // The youngest producer (EX) wins over the older one (MEM).
    if (ex_hit1)       op1_sel = ex_result;
    else if (mem_hit1) op1_sel = mem_result;
    if (ex_hit2)       op2_sel = ex_result;
    else if (mem_hit2) op2_sel = mem_result;
    // A load's data is not available in EX; wait one cycle for MEM bypass.
    hazard_stall = in_valid && out_is_load && (ex_hit1 || ex_hit2);
`else
    // Without bypass, any pending write to a source must retire first.
    hazard_stall = in_valid && (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2);
`endif
  end

  assign in_ready = !flush && !hazard_stall && (out_ready || !out_valid);
  assign capture  = in_valid && in_ready;

  // Output register: reset/flush clear, capture loads, a drained or stalled
  // slot becomes an all-zero bubble, a back-pressured slot holds.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset || flush) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_op1     <= op1_sel;
      out_op2     <= op2_sel;
      out_pc      <= pc;
      out_imm     <= imm;
      out_rd      <= rd;
      out_rd_we   <= rd_we;
      out_is_load <= is_load;
    end else if (out_ready || !out_valid) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end
  end

  // Saturating count of cycles lost to hazards; squashed cycles don't count.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (hazard_stall && !flush && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: a directed vector table, directed
// multi-cycle sequences for the forwarding/stall corner cases, and a random
// run checked against a behavioural model. Follows OPERAND_FORWARDING_EN.
module tb_operand_stage;

`ifdef OPERAND_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        reset, in_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, is_load;
    logic [63:0] pc, imm, rf1, rf2, ex_result;
    logic        mem_valid, mem_we;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result;
    logic        flush, out_ready;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        hz, rdy;          // sampled before the edge
    logic        valid;            // sampled after the edge
    logic [63:0] op1, op2;
    logic [4:0]  rd;
    logic        we, ld;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [63:0] op1, op2, pc, imm;
    logic [4:0]  rd;
    logic        we, ld;
  } out_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, rd_we, is_load, mem_valid, mem_we, flush;
  logic out_valid, out_ready, out_rd_we, out_is_load, hazard_stall;
  logic [4:0]  rs1, rs2, rd, mem_rd, out_rd;
  logic [63:0] pc, imm, rf_data1, rf_data2, ex_result, mem_result;
  logic [63:0] out_op1, out_op2, out_pc, out_imm;
  logic [31:0] stall_cycles;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .is_load(is_load),
    .pc(pc), .imm(imm),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_pc(out_pc), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic stim_t instr(input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] d, input logic we, input logic ld,
                                  input logic [63:0] d1, input logic [63:0] d2);
    stim_t s;
    s = '{reset: 1'b0, in_valid: 1'b1, rs1: r1, rs2: r2, rd: d, rd_we: we, is_load: ld,
          pc: 64'h1000 + 64'(d), imm: 64'h20 + 64'(d), rf1: d1, rf2: d2,
          ex_result: 64'hDEAD, mem_valid: 1'b0, mem_we: 1'b0, mem_rd: 5'd0,
          mem_result: 64'hBEEF, flush: 1'b0, out_ready: 1'b1};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.reset; in_valid = s.in_valid; rs1 = s.rs1; rs2 = s.rs2; rd = s.rd;
    rd_we = s.rd_we; is_load = s.is_load; pc = s.pc; imm = s.imm;
    rf_data1 = s.rf1; rf_data2 = s.rf2; ex_result = s.ex_result;
    mem_valid = s.mem_valid; mem_we = s.mem_we; mem_rd = s.mem_rd;
    mem_result = s.mem_result; flush = s.flush; out_ready = s.out_ready;
  endtask

  // Apply one cycle: drive at the falling edge, sample the combinational
  // outputs just after, then return 1 time unit past the rising edge.
  task automatic cyc(input stim_t s, output logic hz, output logic rdy);
    @(negedge clk);
    drive(s);
    #1;
    hz  = hazard_stall;
    rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  out_t        m;
  logic [31:0] m_stall;

  // Is a source register about to be written by the instruction in EX / MEM?
  function automatic bit pending_ex(input logic [4:0] r);
    return m.valid && m.we && (m.rd == r) && (r != 5'd0);
  endfunction

  function automatic bit pending_mem(input stim_t s, input logic [4:0] r);
    return s.mem_valid && s.mem_we && (s.mem_rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [63:0] source_value(input stim_t s, input logic [4:0] r,
                                               input logic [63:0] rf);
    if (!FWD) return rf;
    if (pending_ex(r)) return s.ex_result;
    if (pending_mem(s, r)) return s.mem_result;
    return rf;
  endfunction

  function automatic bit model_hazard(input stim_t s);
    bit ex_dep, mem_dep;
    ex_dep  = pending_ex(s.rs1) || pending_ex(s.rs2);
    mem_dep = pending_mem(s, s.rs1) || pending_mem(s, s.rs2);
    if (!s.in_valid) return 1'b0;
    return FWD ? (ex_dep && m.ld) : (ex_dep || mem_dep);
  endfunction

  function automatic bit model_ready(input stim_t s);
    return !s.flush && !model_hazard(s) && (s.out_ready || !m.valid);
  endfunction

  task automatic model_step(input stim_t s);
    out_t nxt;
    nxt = '{valid: 1'b0, op1: '0, op2: '0, pc: '0, imm: '0, rd: '0, we: 1'b0, ld: 1'b0};
    if (s.reset) begin
      m_stall = 32'd0;
      m = nxt;
    end else begin
      if (model_hazard(s) && !s.flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!s.flush && s.in_valid && model_ready(s))
        m = '{valid: 1'b1, op1: source_value(s, s.rs1, s.rf1),
              op2: source_value(s, s.rs2, s.rf2), pc: s.pc, imm: s.imm,
              rd: s.rd, we: s.rd_we, ld: s.is_load};
      else if (s.flush || s.out_ready || !m.valid)
        m = nxt;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
              {$urandom, $urandom}, {$urandom, $urandom});
    s.in_valid   = ($urandom_range(0, 3) != 0);
    s.ex_result  = {$urandom, $urandom};
    s.mem_valid  = 1'($urandom);
    s.mem_we     = 1'($urandom);
    s.mem_rd     = 5'($urandom_range(0, 3));
    s.mem_result = {$urandom, $urandom};
    s.flush      = ($urandom_range(0, 15) == 0);
    s.reset      = ($urandom_range(0, 63) == 0);
    s.out_ready  = ($urandom_range(0, 3) != 0);
    s.pc         = {$urandom, $urandom};
    s.imm        = {$urandom, $urandom};
    return s;
  endfunction

  task automatic check_vec(input string tag, input vec_t v, input logic hz, input logic rdy);
    check({tag, " hazard_stall"}, 64'(hz), 64'(v.hz));
    check({tag, " in_ready"}, 64'(rdy), 64'(v.rdy));
    check({tag, " out_valid"}, 64'(out_valid), 64'(v.valid));
    check({tag, " out_op1"}, out_op1, v.op1);
    check({tag, " out_op2"}, out_op2, v.op2);
    check({tag, " out_rd"}, 64'(out_rd), 64'(v.rd));
    check({tag, " out_rd_we"}, 64'(out_rd_we), 64'(v.we));
    check({tag, " out_is_load"}, 64'(out_is_load), 64'(v.ld));
  endtask

  vec_t  vec[12];
  stim_t s, idle;
  logic  hz, rdy;

  initial begin
    // ---------------- directed vector table ----------------
    idle = instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle.in_valid = 1'b0;

    vec[0].s = instr(1, 2, 5, 1, 0, 64'hA, 64'hB);  vec[0].s.reset = 1'b1;
    vec[0].hz = 0; vec[0].rdy = 1; vec[0].valid = 0; vec[0].op1 = 0; vec[0].op2 = 0;
    vec[0].rd = 0; vec[0].we = 0; vec[0].ld = 0;
    vec[1].s = instr(1, 2, 5, 1, 0, 64'hA, 64'hB);
    vec[1].hz = 0; vec[1].rdy = 1; vec[1].valid = 1; vec[1].op1 = 64'hA; vec[1].op2 = 64'hB;
    vec[1].rd = 5; vec[1].we = 1; vec[1].ld = 0;
    vec[2].s = instr(0, 3, 0, 1, 0, 64'h0, 64'hC);
    vec[2].hz = 0; vec[2].rdy = 1; vec[2].valid = 1; vec[2].op1 = 0; vec[2].op2 = 64'hC;
    vec[2].rd = 0; vec[2].we = 1; vec[2].ld = 0;
    // x0 in EX "writing" 0xFF must not be forwarded
    vec[3].s = instr(0, 6, 9, 0, 0, 64'h0, 64'hD);  vec[3].s.ex_result = 64'hFF;
    vec[3].hz = 0; vec[3].rdy = 1; vec[3].valid = 1; vec[3].op1 = 0; vec[3].op2 = 64'hD;
    vec[3].rd = 9; vec[3].we = 0; vec[3].ld = 0;
    // three cycles of back-pressure: everything holds, input blocked
    for (int i = 4; i <= 6; i++) begin
      vec[i].s = instr(1, 2, 7, 1, 1, 64'h1, 64'h2);  vec[i].s.out_ready = 1'b0;
      vec[i].hz = 0; vec[i].rdy = 0; vec[i].valid = 1; vec[i].op1 = 0; vec[i].op2 = 64'hD;
      vec[i].rd = 9; vec[i].we = 0; vec[i].ld = 0;
    end
    // flush wins over hold and blocks the incoming instruction
    vec[7].s = instr(1, 2, 7, 1, 1, 64'h1, 64'h2);  vec[7].s.out_ready = 1'b0;
    vec[7].s.flush = 1'b1;
    vec[7].hz = 0; vec[7].rdy = 0; vec[7].valid = 0; vec[7].op1 = 0; vec[7].op2 = 0;
    vec[7].rd = 0; vec[7].we = 0; vec[7].ld = 0;
    vec[8].s = idle;
    vec[8].hz = 0; vec[8].rdy = 1; vec[8].valid = 0; vec[8].op1 = 0; vec[8].op2 = 0;
    vec[8].rd = 0; vec[8].we = 0; vec[8].ld = 0;
    vec[9].s = instr(4, 0, 2, 1, 1, 64'h44, 64'h0);
    vec[9].hz = 0; vec[9].rdy = 1; vec[9].valid = 1; vec[9].op1 = 64'h44; vec[9].op2 = 0;
    vec[9].rd = 2; vec[9].we = 1; vec[9].ld = 1;
    // drained slot becomes an all-zero bubble
    vec[10].s = idle;
    vec[10].hz = 0; vec[10].rdy = 1; vec[10].valid = 0; vec[10].op1 = 0; vec[10].op2 = 0;
    vec[10].rd = 0; vec[10].we = 0; vec[10].ld = 0;
    vec[11].s = idle;  vec[11].s.out_ready = 1'b0;
    vec[11].hz = 0; vec[11].rdy = 1; vec[11].valid = 0; vec[11].op1 = 0; vec[11].op2 = 0;
    vec[11].rd = 0; vec[11].we = 0; vec[11].ld = 0;

    drive(idle);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(vec[i].s, hz, rdy);
      check_vec($sformatf("vec%0d", i), vec[i], hz, rdy);
      if (i == 0) check("vec0 stall_cycles", 64'(stall_cycles), 64'd0);
      if (i == 1) check("vec1 out_pc", out_pc, 64'h1005);
    end

    // ---------------- reset in the middle of a stall ----------------
    s = idle; s.reset = 1'b1; cyc(s, hz, rdy);
    cyc(instr(1, 2, 7, 1, 1, 64'h1, 64'h2), hz, rdy);          // load x7 into EX
    s = instr(7, 0, 3, 1, 0, 64'h70, 64'h0); s.reset = 1'b1;
    cyc(s, hz, rdy);
    check("rst_stall hazard", 64'(hz), 64'd1);
    check("rst_stall out_valid", 64'(out_valid), 64'd0);
    check("rst_stall stall_cycles", 64'(stall_cycles), 64'd0);
    s.reset = 1'b0;
    cyc(s, hz, rdy);
    check("rst_resume out_valid", 64'(out_valid), 64'd1);
    check("rst_resume out_op1", out_op1, 64'h70);
    check("rst_resume out_rd", 64'(out_rd), 64'd3);

`ifdef OPERAND_FORWARDING_EN
    // ---------------- forwarding sequences ----------------
    s = idle; s.reset = 1'b1; cyc(s, hz, rdy);
    cyc(instr(1, 2, 5, 1, 0, 64'h1, 64'h2), hz, rdy);          // add x5
    s = instr(5, 0, 6, 1, 0, 64'h99, 64'h0); s.ex_result = 64'h2A;
    cyc(s, hz, rdy);
    check("ex_fwd hazard", 64'(hz), 64'd0);
    check("ex_fwd out_op1", out_op1, 64'h2A);

    cyc(instr(1, 2, 3, 1, 0, 64'h1, 64'h2), hz, rdy);          // writer of x3
    s = instr(3, 0, 8, 1, 0, 64'h33, 64'h0);
    s.ex_result = 64'h11; s.mem_valid = 1'b1; s.mem_we = 1'b1; s.mem_rd = 5'd3;
    s.mem_result = 64'h22;
    cyc(s, hz, rdy);
    check("ex_over_mem out_op1", out_op1, 64'h11);

    // load-use: one bubble, then MEM forwarding
    s = idle; s.reset = 1'b1; cyc(s, hz, rdy);
    cyc(instr(1, 2, 7, 1, 1, 64'h1, 64'h2), hz, rdy);          // load x7
    s = instr(1, 7, 4, 1, 0, 64'h5, 64'h6);
    cyc(s, hz, rdy);
    check("load_use hazard", 64'(hz), 64'd1);
    check("load_use in_ready", 64'(rdy), 64'd0);
    check("load_use bubble valid", 64'(out_valid), 64'd0);
    check("load_use bubble rd_we", 64'(out_rd_we), 64'd0);
    check("load_use bubble is_load", 64'(out_is_load), 64'd0);
    s.mem_valid = 1'b1; s.mem_we = 1'b1; s.mem_rd = 5'd7; s.mem_result = 64'h1234;
    cyc(s, hz, rdy);
    check("load_use mem hazard", 64'(hz), 64'd0);
    check("load_use out_valid", 64'(out_valid), 64'd1);
    check("load_use out_op2", out_op2, 64'h1234);
    check("load_use stall_cycles", 64'(stall_cycles), 64'd1);
`else
    // ---------------- no-forwarding sequences ----------------
    s = idle; s.reset = 1'b1; cyc(s, hz, rdy);
    s = instr(4, 0, 1, 1, 0, 64'h40, 64'h0);
    s.mem_valid = 1'b1; s.mem_we = 1'b1; s.mem_rd = 5'd4; s.mem_result = 64'h99;
    for (int i = 0; i < 2; i++) begin
      cyc(s, hz, rdy);
      check($sformatf("mem_dep%0d hazard", i), 64'(hz), 64'd1);
      check($sformatf("mem_dep%0d out_valid", i), 64'(out_valid), 64'd0);
    end
    s.mem_valid = 1'b0;
    cyc(s, hz, rdy);
    check("mem_dep clear hazard", 64'(hz), 64'd0);
    check("mem_dep out_op1", out_op1, 64'h40);
    check("mem_dep stall_cycles", 64'(stall_cycles), 64'd2);
    // non-load EX dependency also stalls
    s = instr(1, 0, 2, 1, 0, 64'h11, 64'h0); s.ex_result = 64'h77;
    cyc(s, hz, rdy);
    check("ex_dep hazard", 64'(hz), 64'd1);
    check("ex_dep out_valid", 64'(out_valid), 64'd0);
    cyc(s, hz, rdy);
    check("ex_dep out_op1", out_op1, 64'h11);
    check("ex_dep stall_cycles", 64'(stall_cycles), 64'd3);
`endif

    // ---------------- random run against the model ----------------
    s = idle; s.reset = 1'b1;
    cyc(s, hz, rdy);
    model_step(s);
    for (int n = 0; n < 3000; n++) begin
      logic e_hz, e_rdy;
      s = rand_stim();
      e_hz  = model_hazard(s);
      e_rdy = model_ready(s);
      cyc(s, hz, rdy);
      model_step(s);
      check("rnd hazard_stall", 64'(hz), 64'(e_hz));
      check("rnd in_ready", 64'(rdy), 64'(e_rdy));
      check("rnd out_valid", 64'(out_valid), 64'(m.valid));
      check("rnd out_op1", out_op1, m.op1);
      check("rnd out_op2", out_op2, m.op2);
      check("rnd out_pc", out_pc, m.pc);
      check("rnd out_imm", out_imm, m.imm);
      check("rnd out_rd", 64'(out_rd), 64'(m.rd));
      check("rnd out_rd_we", 64'(out_rd_we), 64'(m.we));
      check("rnd out_is_load", 64'(out_is_load), 64'(m.ld));
      check("rnd stall_cycles", 64'(stall_cycles), 64'(m_stall));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
